// File: rtl/spi_reg_bridge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_reg_bridge : SPI slave byte stream -> single-cycle register bus, with
// auto-increment bursts. Optional macro SPI_REG_BRIDGE_WR_ECHO_EN. Rev 1.0
// ---------------------------------------------------------------------------
module spi_reg_bridge #(
  parameter int unsigned ADDR_W      = 7,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5,
  parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_RX_DV,
  input  logic [7:0]        i_RX_Byte,
  output logic              o_TX_DV,
  output logic [7:0]        o_TX_Byte,
  input  logic              i_SPI_CS_n,
  output logic [ADDR_W-1:0] o_Reg_Addr,
  output logic              o_Reg_WE,
  output logic [7:0]        o_Reg_WData,
  output logic              o_Reg_RE,
  input  logic [7:0]        i_Reg_RData,
  output logic              o_Busy,
  output logic              o_Overrun
);

`ifdef SPI_REG_BRIDGE_WR_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WR, S_RD_REQ, S_RD_CAP, S_RD_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic                cs_meta_q, cs_sync_q, cs_prev_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                we_q, we_d, re_q, re_d, tx_dv_q, tx_dv_d;
  logic                busy_q, busy_d, ovr_q, ovr_d;
  logic                init_q, idle_pend_q, idle_pend_d;
  logic                cs_rise, cs_fall;

  assign cs_rise = cs_sync_q & ~cs_prev_q;
  assign cs_fall = ~cs_sync_q & cs_prev_q;

  // Synchroniser flops reset to the deasserted (high) level so reset never fakes an edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      tx_byte_q   <= IDLE_BYTE;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      tx_dv_q     <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
      init_q      <= 1'b1;
      idle_pend_q <= 1'b0;
    end else begin
      cs_meta_q   <= i_SPI_CS_n;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_byte_q   <= tx_byte_d;
      we_q        <= we_d;
      re_q        <= re_d;
      tx_dv_q     <= tx_dv_d;
      busy_q      <= busy_d;
      ovr_q       <= ovr_d;
      init_q      <= 1'b0;
      idle_pend_q <= idle_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tx_byte_d   = tx_byte_q;
    we_d        = 1'b0;
    re_d        = 1'b0;
    tx_dv_d     = 1'b0;
    busy_d      = busy_q;
    ovr_d       = ovr_q;
    idle_pend_d = 1'b0;

    // Address advances the cycle after each write strobe.
    if (we_q) addr_d = addr_q + ADDR_W'(1);

    if (init_q || idle_pend_q) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = IDLE_BYTE;
    end

    if (cs_rise) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      if (state_q == S_WR && i_RX_DV) begin
        // Last byte still lands; the idle preload is deferred one cycle.
        we_d        = 1'b1;
        wdata_d     = i_RX_Byte;
        idle_pend_d = 1'b1;
        if (ECHO) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = i_RX_Byte;
        end
      end else begin
        tx_dv_d   = 1'b1;
        tx_byte_d = IDLE_BYTE;
      end
    end else if (cs_fall) begin
      state_d = S_CMD;
      busy_d  = 1'b1;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_CMD: begin
          if (i_RX_DV) begin
            addr_d = i_RX_Byte[ADDR_W-1:0];
            if (i_RX_Byte[7]) begin
              state_d = S_RD_REQ;
              re_d    = 1'b1;
            end else begin
              state_d   = S_WR;
              tx_dv_d   = 1'b1;
              tx_byte_d = STATUS_BYTE;
            end
          end
        end
        S_WR: begin
          if (i_RX_DV) begin
            we_d    = 1'b1;
            wdata_d = i_RX_Byte;
            if (ECHO) begin
              tx_dv_d   = 1'b1;
              tx_byte_d = i_RX_Byte;
            end
          end
        end
        S_RD_REQ: begin
          if (i_RX_DV) ovr_d = 1'b1;
          state_d = S_RD_CAP;
        end
        S_RD_CAP: begin
          if (i_RX_DV) ovr_d = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = i_Reg_RData;
          state_d   = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (i_RX_DV) begin
            addr_d  = addr_q + ADDR_W'(1);
            re_d    = 1'b1;
            state_d = S_RD_REQ;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_TX_DV     = tx_dv_q;
  assign o_TX_Byte   = tx_byte_q;
  assign o_Reg_Addr  = addr_q;
  assign o_Reg_WE    = we_q;
  assign o_Reg_WData = wdata_q;
  assign o_Reg_RE    = re_q;
  assign o_Busy      = busy_q;
  assign o_Overrun   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// tb_spi_reg_bridge : directed self-checking bench for spi_reg_bridge. Rev 1.0
module tb_spi_reg_bridge;

  logic       clk = 1'b0;
  logic       rst_n, rx_dv, cs_n;
  logic [7:0] rx_byte;
  logic [7:0] rdata = 8'h00;
  logic       tx_dv, reg_we, reg_re, busy, ovr;
  logic [7:0] tx_byte, reg_wdata;
  logic [6:0] reg_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] regs [0:127];

  // event logs filled by the monitor
  logic [7:0] tx_b [0:255];
  int         tx_c [0:255];
  int         tx_n = 0;
  logic [6:0] we_a [0:255];
  logic [7:0] we_d [0:255];
  int         we_c [0:255];
  int         we_n = 0;
  logic [6:0] re_a [0:255];
  int         re_c [0:255];
  int         re_n = 0;

  always #5 clk = ~clk;

  spi_reg_bridge dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .i_SPI_CS_n  (cs_n),
    .o_Reg_Addr  (reg_addr),
    .o_Reg_WE    (reg_we),
    .o_Reg_WData (reg_wdata),
    .o_Reg_RE    (reg_re),
    .i_Reg_RData (rdata),
    .o_Busy      (busy),
    .o_Overrun   (ovr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (reg_re) rdata <= regs[reg_addr];

  always @(negedge clk) begin
    if (tx_dv && tx_n < 256) begin
      tx_b[tx_n] = tx_byte; tx_c[tx_n] = cyc; tx_n = tx_n + 1;
    end
    if (reg_we && we_n < 256) begin
      we_a[we_n] = reg_addr; we_d[we_n] = reg_wdata; we_c[we_n] = cyc; we_n = we_n + 1;
    end
    if (reg_re && re_n < 256) begin
      re_a[re_n] = reg_addr; re_c[re_n] = cyc; re_n = re_n + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, output int t);
    rx_byte = b; rx_dv = 1'b1; t = cyc;
    tick(1);
    rx_dv = 1'b0;
  endtask

  task automatic cs_low();
    cs_n = 1'b0; tick(5);
  endtask

  task automatic cs_high();
    cs_n = 1'b1; tick(5);
  endtask

  task automatic test_reset();
    int b, r;
    rst_n = 1'b0; cs_n = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
    tick(3);
    checks++;
    if ({tx_dv, reg_we, reg_re, busy, ovr} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=00000", {tx_dv, reg_we, reg_re, busy, ovr});
    end
    checks++;
    if (tx_byte !== 8'hFF) begin failures++; $display("FAIL reset_tx_byte got=%h exp=ff", tx_byte); end
    checks++;
    if (reg_addr !== 7'h00 || reg_wdata !== 8'h00) begin
      failures++; $display("FAIL reset_addr_wdata got=%h/%h exp=00/00", reg_addr, reg_wdata);
    end
    b = tx_n;
    rst_n = 1'b1; r = cyc;
    tick(4);
    checks++;
    if (tx_n - b !== 1) begin failures++; $display("FAIL reset_tx_count got=%0d exp=1", tx_n - b); end
    checks++;
    if (tx_b[b] !== 8'hFF || tx_c[b] !== r + 1) begin
      failures++; $display("FAIL reset_tx_pulse got=%h@%0d exp=ff@%0d", tx_b[b], tx_c[b], r + 1);
    end
    checks++;
    if (busy !== 1'b0 || reg_we !== 1'b0 || reg_re !== 1'b0) begin
      failures++; $display("FAIL reset_idle got=%b%b%b exp=000", busy, reg_we, reg_re);
    end
  endtask

  task automatic test_write();
    int tb, wb, t0, t1, t2;
    tb = tx_n; wb = we_n;
    cs_low();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL write_busy got=%b exp=1", busy); end
    send(8'h05, t0); tick(8);
    send(8'h11, t1); tick(8);
    send(8'h22, t2); tick(8);
    cs_high();
    checks++;
    if (we_n - wb !== 2) begin failures++; $display("FAIL write_we_count got=%0d exp=2", we_n - wb); end
    checks++;
    if (we_a[wb] !== 7'h05 || we_d[wb] !== 8'h11 || we_c[wb] !== t1 + 1) begin
      failures++; $display("FAIL write_we0 got=%h:%h@%0d exp=05:11@%0d", we_a[wb], we_d[wb], we_c[wb], t1 + 1);
    end
    checks++;
    if (we_a[wb+1] !== 7'h06 || we_d[wb+1] !== 8'h22 || we_c[wb+1] !== t2 + 1) begin
      failures++; $display("FAIL write_we1 got=%h:%h@%0d exp=06:22@%0d", we_a[wb+1], we_d[wb+1], we_c[wb+1], t2 + 1);
    end
    checks++;
    if (tx_b[tb] !== 8'hA5 || tx_c[tb] !== t0 + 1) begin
      failures++; $display("FAIL write_status got=%h@%0d exp=a5@%0d", tx_b[tb], tx_c[tb], t0 + 1);
    end
`ifdef SPI_REG_BRIDGE_WR_ECHO_EN
    checks++;
    if (tx_n - tb !== 4 || tx_b[tb+1] !== 8'h11 || tx_c[tb+1] !== t1 + 1 || tx_b[tb+2] !== 8'h22 || tx_b[tb+3] !== 8'hFF) begin
      failures++; $display("FAIL write_echo got=n%0d %h %h %h exp=n4 11 22 ff", tx_n - tb, tx_b[tb+1], tx_b[tb+2], tx_b[tb+3]);
    end
`else
    checks++;
    if (tx_n - tb !== 2 || tx_b[tb+1] !== 8'hFF) begin
      failures++; $display("FAIL write_tx_seq got=n%0d %h exp=n2 ff", tx_n - tb, tx_b[tb+1]);
    end
`endif
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_read();
    int tb, rb, t0, t1, t2;
    regs[3] = 8'h3C; regs[4] = 8'h4D; regs[5] = 8'h5E;
    tb = tx_n; rb = re_n;
    cs_low();
    send(8'h83, t0); tick(8);
    send(8'h00, t1); tick(8);
    send(8'h00, t2); tick(8);
    cs_high();
    checks++;
    if (re_n - rb !== 3) begin failures++; $display("FAIL read_re_count got=%0d exp=3", re_n - rb); end
    checks++;
    if (re_a[rb] !== 7'h03 || re_c[rb] !== t0 + 1) begin
      failures++; $display("FAIL read_re0 got=%h@%0d exp=03@%0d", re_a[rb], re_c[rb], t0 + 1);
    end
    checks++;
    if (re_a[rb+1] !== 7'h04 || re_a[rb+2] !== 7'h05) begin
      failures++; $display("FAIL read_re_addrs got=%h,%h exp=04,05", re_a[rb+1], re_a[rb+2]);
    end
    checks++;
    if (tx_n - tb !== 4) begin failures++; $display("FAIL read_tx_count got=%0d exp=4", tx_n - tb); end
    checks++;
    if (tx_b[tb] !== 8'h3C || tx_c[tb] !== t0 + 3) begin
      failures++; $display("FAIL read_tx0 got=%h@%0d exp=3c@%0d", tx_b[tb], tx_c[tb], t0 + 3);
    end
    checks++;
    if (tx_b[tb+1] !== 8'h4D || tx_c[tb+1] !== t1 + 3 || tx_b[tb+2] !== 8'h5E || tx_c[tb+2] !== t2 + 3) begin
      failures++; $display("FAIL read_tx12 got=%h@%0d %h@%0d exp=4d@%0d 5e@%0d",
                           tx_b[tb+1], tx_c[tb+1], tx_b[tb+2], tx_c[tb+2], t1 + 3, t2 + 3);
    end
    checks++;
    if (tx_b[tb+3] !== 8'hFF || ovr !== 1'b0) begin
      failures++; $display("FAIL read_end got=%h ovr=%b exp=ff ovr=0", tx_b[tb+3], ovr);
    end
  endtask

  task automatic test_wrap();
    int wb, t0, t1, t2;
    wb = we_n;
    cs_low();
    send(8'h7F, t0); tick(8);
    send(8'hAA, t1); tick(8);
    send(8'hBB, t2); tick(8);
    cs_high();
    checks++;
    if (we_n - wb !== 2 || we_a[wb] !== 7'h7F || we_d[wb] !== 8'hAA) begin
      failures++; $display("FAIL wrap_we0 got=n%0d %h:%h exp=n2 7f:aa", we_n - wb, we_a[wb], we_d[wb]);
    end
    checks++;
    if (we_a[wb+1] !== 7'h00 || we_d[wb+1] !== 8'hBB) begin
      failures++; $display("FAIL wrap_we1 got=%h:%h exp=00:bb", we_a[wb+1], we_d[wb+1]);
    end
  endtask

  task automatic test_overrun();
    int tb, rb, t0;
    regs[1] = 8'h17;
    cs_low();
    tb = tx_n; rb = re_n;
    rx_byte = 8'h81; rx_dv = 1'b1; t0 = cyc;
    tick(1);
    rx_byte = 8'h99;
    tick(1);
    rx_dv = 1'b0;
    tick(8);
    checks++;
    if (ovr !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", ovr); end
    checks++;
    if (re_n - rb !== 1 || re_a[rb] !== 7'h01) begin
      failures++; $display("FAIL ovr_single_re got=n%0d %h exp=n1 01", re_n - rb, re_a[rb]);
    end
    checks++;
    if (tx_n - tb !== 1 || tx_b[tb] !== 8'h17 || tx_c[tb] !== t0 + 3) begin
      failures++; $display("FAIL ovr_tx got=n%0d %h@%0d exp=n1 17@%0d", tx_n - tb, tx_b[tb], tx_c[tb], t0 + 3);
    end
    cs_high();
    checks++;
    if (ovr !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", ovr); end
    cs_low();
    checks++;
    if (ovr !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", ovr); end
    cs_high();
  endtask

  task automatic test_cs_rise_write();
    int tb, wb, rb, t0, t1, k;
    cs_low();
    send(8'h20, t0); tick(8);
    tb = tx_n; wb = we_n;
    cs_n = 1'b1; k = cyc;
    tick(2);
    send(8'h5A, t1);
    tick(6);
    checks++;
    if (we_n - wb !== 1 || we_a[wb] !== 7'h20 || we_d[wb] !== 8'h5A || we_c[wb] !== k + 3) begin
      failures++; $display("FAIL rise_we got=n%0d %h:%h@%0d exp=n1 20:5a@%0d", we_n - wb, we_a[wb], we_d[wb], we_c[wb], k + 3);
    end
`ifdef SPI_REG_BRIDGE_WR_ECHO_EN
    checks++;
    if (tx_n - tb !== 2 || tx_b[tb] !== 8'h5A || tx_c[tb] !== k + 3 || tx_b[tb+1] !== 8'hFF || tx_c[tb+1] !== k + 4) begin
      failures++; $display("FAIL rise_tx got=n%0d %h@%0d %h@%0d exp=n2 5a@%0d ff@%0d",
                           tx_n - tb, tx_b[tb], tx_c[tb], tx_b[tb+1], tx_c[tb+1], k + 3, k + 4);
    end
`else
    checks++;
    if (tx_n - tb !== 1 || tx_b[tb] !== 8'hFF || tx_c[tb] !== k + 4) begin
      failures++; $display("FAIL rise_tx got=n%0d %h@%0d exp=n1 ff@%0d", tx_n - tb, tx_b[tb], tx_c[tb], k + 4);
    end
`endif
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rise_busy got=%b exp=0", busy); end
    tb = tx_n; wb = we_n; rb = re_n;
    send(8'h85, t0); tick(6);
    checks++;
    if (tx_n != tb || we_n != wb || re_n != rb) begin
      failures++; $display("FAIL idle_rx_ignored got=tx%0d we%0d re%0d exp=0 0 0", tx_n - tb, we_n - wb, re_n - rb);
    end
  endtask

  task automatic test_reset_mid();
    int tb, t0;
    cs_low();
    tb = tx_n;
    send(8'h83, t0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (reg_re !== 1'b0 || busy !== 1'b0 || tx_byte !== 8'hFF || reg_addr !== 7'h00) begin
      failures++; $display("FAIL midrst_vals got=re%b busy%b tx%h a%h exp=re0 busy0 txff a00", reg_re, busy, tx_byte, reg_addr);
    end
    tick(2);
    cs_n = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    checks++;
    if (tx_n - tb !== 1 || tx_b[tb] !== 8'hFF) begin
      failures++; $display("FAIL midrst_tx got=n%0d %h exp=n1 ff", tx_n - tb, tx_b[tb]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_overrun();
    test_cs_rise_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Command/register bridge directly downstream of the SPI slave.
- Consumes received bytes (RX_DV/RX_Byte) and drives the slave's TX load (TX_DV/TX_Byte).
- Decodes a byte protocol into a simple single-cycle register bus with auto-increment bursts.
- Sits between the SPI slave and the FPGA control/status register bank, all in the i_Clk domain.

Parameters:
- ADDR_W, 7, register address width; fixed by command byte format, must be ≤ 7.
- STATUS_BYTE, 8'hA5, byte returned on MISO during the command byte's successor in write transactions.
- IDLE_BYTE, 8'hFF, byte preloaded into the slave when no transaction is active.

Ports:
- i_Clk  input  1  FPGA clock (same clock as SPI slave i_Clk).
- i_Rst_L  input  1  asynchronous active-low reset.
- i_RX_DV  input  1  one-cycle pulse, received byte valid.
- i_RX_Byte  input  8  received byte.
- o_TX_DV  output  1  one-cycle pulse, load o_TX_Byte into slave.
- o_TX_Byte  output  8  next byte to shift out on MISO.
- i_SPI_CS_n  input  1  raw chip select (asynchronous; synchronised internally).
- o_Reg_Addr  output  ADDR_W  register address.
- o_Reg_WE  output  1  one-cycle write strobe.
- o_Reg_WData  output  8  write data, valid with o_Reg_WE.
- o_Reg_RE  output  1  one-cycle read strobe.
- i_Reg_RData  input  8  read data, valid exactly 1 cycle after o_Reg_RE.
- o_Busy  output  1  high while CS (synchronised) is low.
- o_Overrun  output  1  sticky error; cleared on next CS assertion.

Behaviour:
- Reset values:
  - o_TX_DV, o_Reg_WE, o_Reg_RE, o_Busy, o_Overrun = 0.
  - o_Reg_Addr = 0, o_Reg_WData = 0.
  - o_TX_Byte = IDLE_BYTE; state S_IDLE.
- One cycle after reset release, emit one o_TX_DV pulse with IDLE_BYTE.
- CS handling:
  - i_SPI_CS_n passes through a 2-FF synchroniser; edges are detected on the synchronised signal.
  - Falling edge: go to S_CMD, clear o_Overrun, set o_Busy.
  - Rising edge from any state: go to S_IDLE, clear o_Busy, pulse o_TX_DV with IDLE_BYTE.
- Command byte (first RX_DV in S_CMD):
  - bit7 = RW (1 = read); bits[ADDR_W-1:0] = start address; unused bits ignored.
  - Latch address into o_Reg_Addr.
  - Write: go to S_WR; pulse o_TX_DV with STATUS_BYTE on the next cycle.
  - Read: go to S_RD_REQ.
- S_WR, on each RX_DV:
  - Next cycle: o_Reg_WE=1, o_Reg_WData=byte, o_Reg_Addr=current address.
  - Following cycle: address increments.
- S_RD_REQ: o_Reg_RE=1 for one cycle, then go to S_RD_CAP.
- S_RD_CAP: capture i_Reg_RData, pulse o_TX_DV with it, go to S_RD_WAIT.
  - Latency: command RX_DV at cycle T → RE at T+1 → TX_DV at T+3.
- S_RD_WAIT, on RX_DV (dummy byte, value ignored): increment address, go to S_RD_REQ.
- Address wraps modulo 2^ADDR_W (e.g. 0x7F → 0x00).
- Overrun: RX_DV arriving in S_RD_REQ or S_RD_CAP sets o_Overrun; the byte is dropped and the pipeline completes normally.
- System constraint: i_Clk ≥ 8× SPI clock, so TX_DV precedes the next byte's first shift edge.
- RX_DV and CS rising edge in the same cycle:
  - In S_WR, the byte's write is still performed; the IDLE_BYTE TX_DV follows one cycle later; then S_IDLE.
  - In S_RD_*, the read is abandoned.
- RX_DV in S_IDLE is ignored (no strobes).
- Reset mid-transaction: immediate return to reset values; no partial strobes.

Optional Feature:
- SPI_REG_BRIDGE_WR_ECHO_EN defined: in S_WR each received data byte is echoed back; o_TX_DV with that byte is pulsed in the same cycle as o_Reg_WE. The master sees byte n on MISO during byte n+1.
- Undefined: during S_WR no further TX_DV after STATUS_BYTE; MISO repeats STATUS_BYTE.

Test Plan:
- Reset → o_TX_DV pulse with 8'hFF, all strobes 0, o_Busy 0.
- CS low, bytes 0x05, 0x11, 0x22 → WE at addr 0x05 data 0x11, then addr 0x06 data 0x22; TX_DV 0xA5 once.
- CS low, byte 0x83 with regs[3]=0x3C, regs[4]=0x4D, then two dummy bytes → RE addr 3, TX_DV 0x3C at T+3; RE addr 4, TX_DV 0x4D.
- Write burst starting 0x7F, two data bytes → writes to 0x7F then 0x00.
- Read command followed by RX_DV one cycle later → o_Overrun=1, single RE, cleared on next CS fall.
- CS rise coincident with RX_DV in write → WE performed, then TX_DV 0xFF, state idle; with SPI_REG_BRIDGE_WR_ECHO_EN, data 0x5A → TX_DV 0x5A with WE.
